ev_session_meter: RTL and testbench
===================================

Name: ev_session_meter

Overview:
- Downstream of the charging controller. Watches its charging flag, state and fault code, plus the voltage and current sensor buses.
- Per charging session it accumulates energy (sum of V*I per cycle) and duration, then classifies why the session ended.
- Each completed session is pushed as a record into a small FIFO, which the billing/host side drains over a valid/ready interface.

Parameters:
- FIFO_DEPTH, 4, number of session records buffered; must be a power of 2, at least 2.
- ENERGY_W, 48, width of the energy accumulator; saturating.
- DUR_W, 32, width of the duration counter in clock cycles; saturating.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- charging  in  1  controller charging flag.
- state  in  4  controller state, one-hot: IDLE=0001, CHARGING=0010, FULL=0100, ERROR=1000.
- slot_id  in  4  controller slot counter.
- fault_code  in  8  controller fault code; 0 means no fault.
- voltage  in  16  unsigned voltage sample.
- current  in  16  unsigned current sample.
- active  out  1  session in progress.
- live_energy  out  ENERGY_W  running energy of the current or last session.
- rec_valid  out  1  FIFO head record valid.
- rec_ready  in  1  consumer accepts the head record.
- rec_slot  out  4  slot of the head record.
- rec_duration  out  DUR_W  cycles charged.
- rec_energy  out  ENERGY_W  accumulated energy.
- rec_cause  out  2  end cause: 1=FULL, 2=ERROR, 3=ABORT; 0 is never emitted.
- rec_fault  out  8  first nonzero fault_code seen in the session, else 0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  records held.
- overflow  out  1  sticky: a record was dropped.
- drop_cnt  out  8  saturating count of dropped records.

Behaviour:
- Reset: all outputs 0, FSM in S_IDLE, FIFO empty, all accumulators 0. Reset mid-session discards the session; no record is produced.
- Power P = voltage*current, 32-bit unsigned, computed combinationally and zero-extended to ENERGY_W.
- FSM states: S_IDLE, S_ACTIVE, S_CLOSE. `active` = (FSM==S_ACTIVE).
- Session start, from S_IDLE or S_CLOSE with charging=1:
  - load acc_e=P, dur=1, slot_l=slot_id, fault_l=fault_code;
  - go to S_ACTIVE.
- S_ACTIVE with charging=1:
  - acc_e = acc_e+P, saturating at all-ones;
  - dur = dur+1, saturating at all-ones;
  - if fault_l==0, fault_l=fault_code; otherwise fault_l holds (first-fault semantics).
- S_ACTIVE with charging=0:
  - latch cause from state in that cycle: 0100 gives FULL, 1000 gives ERROR, any other value gives ABORT;
  - no accumulation that cycle;
  - go to S_CLOSE.
- S_CLOSE, exactly 1 cycle:
  - push {slot_l, dur, acc_e, cause, fault_l} into the FIFO;
  - go to S_IDLE, or straight back to S_ACTIVE with a fresh session load if charging=1.
- live_energy = acc_e. It holds its value after close until the next session load.
- Latency: a record becomes visible on rec_valid 1 cycle after S_CLOSE, i.e. 2 cycles after the charging falling edge is sampled.
- FIFO, first-word-fall-through:
  - rec_* always reflects the head entry; rec_valid = (count!=0).
  - A pop occurs when rec_valid && rec_ready.
  - rec_* must be stable while rec_valid=1 and rec_ready=0.
- FIFO boundary cases:
  - Push when full and no pop in the same cycle: drop the record, set overflow (cleared only by reset), drop_cnt+1 saturating at 255. The FIFO contents are unchanged.
  - Push when full with a simultaneous pop: accepted; count is unchanged.
  - Pop when empty: ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- A session of exactly 1 charging cycle is legal: dur=1, acc_e=P of that cycle.
- Inputs are sampled only on the rising clock edge; no other edge detection is performed.

Decomposition:
- Shared package ev_pkg:
  - controller state encodings ST_IDLE, ST_CHARGING, ST_FULL, ST_ERROR;
  - end-cause constants CAUSE_FULL, CAUSE_ERROR, CAUSE_ABORT;
  - the session record struct type and its packed width.
- One sub-module: ev_record_fifo, a parameterised FWFT FIFO with full/empty/count outputs. The session FSM, accumulators and drop logic stay in ev_session_meter.

Test Plan:
- voltage=2000, current=10, charging high for 5 cycles, then low with state=0100 -> one record: rec_energy=100000, rec_duration=5, rec_cause=1, rec_fault=0; rec_valid rises 2 cycles after the low sample.
- Same session, but fault_code=1 on cycle 3 and 0 after, ending with state=1000 -> rec_fault=1, rec_cause=2.
- voltage=65535, current=65535 held with ENERGY_W=33 -> live_energy saturates at 2^33-1 and does not wrap.
- rec_ready=0, five 1-cycle sessions with FIFO_DEPTH=4 -> fifo_count=4, overflow=1, drop_cnt=1; draining returns the first four records in order.
- FIFO full, rec_ready=1 in the same cycle as a push -> count stays 4, overflow stays 0, new record present at the tail.
- Assert reset on cycle 3 of a session -> active=0, live_energy=0, fifo_count=0, and no record appears after reset release.

Source files
------------

// File: rtl/ev_pkg.sv
// Shared encodings and record layout for the EV session meter.
// Energy and duration widths are parameters of the top, so the struct holds the fixed-width fields.
package ev_pkg;

   localparam logic [3:0] ST_IDLE     = 4'b0001;
   localparam logic [3:0] ST_CHARGING = 4'b0010;
   localparam logic [3:0] ST_FULL     = 4'b0100;
   localparam logic [3:0] ST_ERROR    = 4'b1000;

   localparam logic [1:0] CAUSE_FULL  = 2'd1;
   localparam logic [1:0] CAUSE_ERROR = 2'd2;
   localparam logic [1:0] CAUSE_ABORT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_CLOSE
   } sess_state_e;

   typedef struct packed {
      logic [3:0] slot;
      logic [1:0] cause;
      logic [7:0] fault;
   } rec_hdr_t;

   localparam int REC_HDR_W = $bits(rec_hdr_t);

   // Full packed record: header, then duration, then energy (LSBs).
   function automatic int rec_w(input int energy_w, input int dur_w);
      return REC_HDR_W + dur_w + energy_w;
   endfunction

endpackage

// File: rtl/ev_record_fifo.sv
// First-word-fall-through FIFO for session records; DEPTH must be a power of 2.
// A write into a full FIFO is accepted only when the same cycle pops the head.
module ev_record_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_wr, do_rd;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is cleared on reset so the head outputs read 0 while empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_wr) mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/ev_session_meter.sv
// Per-session energy/duration meter: accumulates V*I while charging, classifies the
// end cause and queues one record per session for the billing side.
module ev_session_meter
   import ev_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ENERGY_W   = 48,
   parameter int DUR_W      = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          charging,
   input  logic [3:0]                    state,
   input  logic [3:0]                    slot_id,
   input  logic [7:0]                    fault_code,
   input  logic [15:0]                   voltage,
   input  logic [15:0]                   current,
   output logic                          active,
   output logic [ENERGY_W-1:0]           live_energy,
   output logic                          rec_valid,
   input  logic                          rec_ready,
   output logic [3:0]                    rec_slot,
   output logic [DUR_W-1:0]              rec_duration,
   output logic [ENERGY_W-1:0]           rec_energy,
   output logic [1:0]                    rec_cause,
   output logic [7:0]                    rec_fault,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [7:0]                    drop_cnt
);

   localparam int REC_W = rec_w(ENERGY_W, DUR_W);

   sess_state_e         state_q, state_d;
   logic [ENERGY_W-1:0] acc_e_q, acc_e_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic [3:0]          slot_q, slot_d;
   logic [7:0]          fault_q, fault_d;
   logic [1:0]          cause_q, cause_d;
   logic                overflow_q, overflow_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;

   logic [31:0]         pwr;
   logic [ENERGY_W-1:0] pwr_e;
   logic [ENERGY_W:0]   e_sum;
   logic                load, push, pop, drop, fifo_full, fifo_empty;
   rec_hdr_t            wr_hdr, rd_hdr;
   logic [REC_W-1:0]    wr_rec, rd_rec;

   assign pwr   = 32'(voltage) * 32'(current);
   assign pwr_e = ENERGY_W'(pwr);
   assign e_sum = {1'b0, acc_e_q} + {1'b0, pwr_e};

   // A new session may start straight out of S_CLOSE, so back-to-back sessions lose no cycle.
   assign load = charging && (state_q == S_IDLE || state_q == S_CLOSE);

   always_comb begin
      state_d = state_q;
      acc_e_d = acc_e_q;
      dur_d   = dur_q;
      slot_d  = slot_q;
      fault_d = fault_q;
      cause_d = cause_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE: ;
         S_ACTIVE: begin
            if (charging) begin
               acc_e_d = e_sum[ENERGY_W] ? '1 : e_sum[ENERGY_W-1:0];
               if (dur_q != '1) dur_d = dur_q + DUR_W'(1);
               if (fault_q == 8'd0) fault_d = fault_code;
            end else begin
               case (state)
                  ST_FULL:  cause_d = CAUSE_FULL;
                  ST_ERROR: cause_d = CAUSE_ERROR;
                  default:  cause_d = CAUSE_ABORT;
               endcase
               state_d = S_CLOSE;
            end
         end
         S_CLOSE: begin
            push    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (load) begin
         state_d = S_ACTIVE;
         acc_e_d = pwr_e;
         dur_d   = DUR_W'(1);
         slot_d  = slot_id;
         fault_d = fault_code;
      end
   end

   assign pop  = rec_valid && rec_ready;
   assign drop = push && fifo_full && !pop;

   always_comb begin
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         acc_e_q    <= '0;
         dur_q      <= '0;
         slot_q     <= '0;
         fault_q    <= '0;
         cause_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_e_q    <= acc_e_d;
         dur_q      <= dur_d;
         slot_q     <= slot_d;
         fault_q    <= fault_d;
         cause_q    <= cause_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign wr_hdr = '{slot: slot_q, cause: cause_q, fault: fault_q};
   assign wr_rec = {wr_hdr, dur_q, acc_e_q};

   ev_record_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (REC_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .wr_en   (push),
      .wr_data (wr_rec),
      .rd_en   (rec_ready),
      .rd_data (rd_rec),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign {rd_hdr, rec_duration, rec_energy} = rd_rec;
   assign rec_slot  = rd_hdr.slot;
   assign rec_cause = rd_hdr.cause;
   assign rec_fault = rd_hdr.fault;
   assign rec_valid = !fifo_empty;

   assign active      = (state_q == S_ACTIVE);
   assign live_energy = acc_e_q;
   assign overflow    = overflow_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_ev_session_meter.sv
// Scoreboard bench for ev_session_meter: stimulus queues expected records, a monitor
// compares each record as the consumer accepts it.
module tb_ev_session_meter;

   localparam int EW = 33;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          charging;
   logic [3:0]    state;
   logic [3:0]    slot_id;
   logic [7:0]    fault_code;
   logic [15:0]   voltage;
   logic [15:0]   current;
   logic          active;
   logic [EW-1:0] live_energy;
   logic          rec_valid;
   logic          rec_ready;
   logic [3:0]    rec_slot;
   logic [DW-1:0] rec_duration;
   logic [EW-1:0] rec_energy;
   logic [1:0]    rec_cause;
   logic [7:0]    rec_fault;
   logic [2:0]    fifo_count;
   logic          overflow;
   logic [7:0]    drop_cnt;

   typedef struct {
      logic [3:0]    slot;
      logic [DW-1:0] dur;
      logic [EW-1:0] energy;
      logic [1:0]    cause;
      logic [7:0]    fault;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   ev_session_meter #(.FIFO_DEPTH(4), .ENERGY_W(EW), .DUR_W(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .charging     (charging),
      .state        (state),
      .slot_id      (slot_id),
      .fault_code   (fault_code),
      .voltage      (voltage),
      .current      (current),
      .active       (active),
      .live_energy  (live_energy),
      .rec_valid    (rec_valid),
      .rec_ready    (rec_ready),
      .rec_slot     (rec_slot),
      .rec_duration (rec_duration),
      .rec_energy   (rec_energy),
      .rec_cause    (rec_cause),
      .rec_fault    (rec_fault),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_rec(input logic [3:0] sl, input logic [DW-1:0] d,
                             input logic [EW-1:0] e, input logic [1:0] ca, input logic [7:0] f);
      exp_t x;
      x.slot = sl; x.dur = d; x.energy = e; x.cause = ca; x.fault = f;
      exp_q.push_back(x);
   endtask

   // n charging cycles, fval on cycle fcyc (1-based), then one low cycle with end_st.
   task automatic sess(input int n, input logic [15:0] v, input logic [15:0] c,
                       input logic [3:0] sl, input logic [3:0] end_st,
                       input int fcyc, input logic [7:0] fval);
      charging = 1'b1; voltage = v; current = c; slot_id = sl; state = 4'b0010;
      for (int k = 1; k <= n; k++) begin
         fault_code = (k == fcyc) ? fval : 8'd0;
         cyc(1);
      end
      fault_code = 8'd0; charging = 1'b0; state = end_st;
      cyc(1);
      state = 4'b0001;
   endtask

   always @(negedge clk) begin
      if (!reset && rec_valid && rec_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_rec: got slot %0d, expected no record", rec_slot);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rec_slot",     64'(rec_slot),     64'(e.slot));
            chk("rec_duration", 64'(rec_duration), 64'(e.dur));
            chk("rec_energy",   64'(rec_energy),   64'(e.energy));
            chk("rec_cause",    64'(rec_cause),    64'(e.cause));
            chk("rec_fault",    64'(rec_fault),    64'(e.fault));
         end
      end
   end

   initial begin
      reset = 1'b1; charging = 1'b0; state = 4'b0001; slot_id = '0; fault_code = '0;
      voltage = '0; current = '0; rec_ready = 1'b0;
      cyc(2);
      chk("rst_active",     64'(active),      0);
      chk("rst_live",       64'(live_energy), 0);
      chk("rst_valid",      64'(rec_valid),   0);
      chk("rst_count",      64'(fifo_count),  0);
      chk("rst_overflow",   64'(overflow),    0);
      chk("rst_drop",       64'(drop_cnt),    0);
      chk("rst_rec_energy", 64'(rec_energy),  0);
      reset = 1'b0;
      cyc(1);

      // basic FULL session, record latency of 2 cycles after the low sample
      rec_ready = 1'b1;
      expect_rec(4'd3, 5, 100000, 2'd1, 8'd0);
      sess(5, 16'd2000, 16'd10, 4'd3, 4'b0100, 0, 8'd0);
      chk("lat_valid_0", 64'(rec_valid), 0);
      chk("lat_active",  64'(active),    0);
      cyc(1);
      chk("lat_valid_1", 64'(rec_valid),   1);
      chk("live_hold",   64'(live_energy), 100000);
      cyc(2);

      // first fault kept, ERROR cause
      expect_rec(4'd5, 5, 100000, 2'd2, 8'd1);
      sess(5, 16'd2000, 16'd10, 4'd5, 4'b1000, 3, 8'd1);
      cyc(3);

      // single-cycle session ending with a non-FULL/ERROR state -> ABORT
      expect_rec(4'd9, 1, 21, 2'd3, 8'd0);
      sess(1, 16'd3, 16'd7, 4'd9, 4'b0001, 1, 8'd0);
      cyc(3);

      // saturation with ENERGY_W=33
      expect_rec(4'd2, 4, 33'h1_FFFF_FFFF, 2'd1, 8'd0);
      charging = 1'b1; voltage = 16'hFFFF; current = 16'hFFFF; slot_id = 4'd2; state = 4'b0010;
      cyc(2);
      chk("sat_two_cycles", 64'(live_energy), 64'd8589672450);
      cyc(2);
      chk("sat_clamped", 64'(live_energy), 64'h1_FFFF_FFFF);
      charging = 1'b0; state = 4'b0100;
      cyc(1);
      state = 4'b0001;
      cyc(3);
      chk("drained_0", 64'(fifo_count), 0);

      // fill to 4, then push with a simultaneous pop
      rec_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         expect_rec(4'(k), 1, 33'(20 * k), 2'd1, 8'd0);
         sess(1, 16'(k), 16'd20, 4'(k), 4'b0100, 0, 8'd0);
      end
      rec_ready = 1'b1;
      cyc(1);
      rec_ready = 1'b0;
      chk("fullpop_count",    64'(fifo_count), 4);
      chk("fullpop_overflow", 64'(overflow),   0);
      chk("fullpop_drop",     64'(drop_cnt),   0);
      chk("fullpop_head",     64'(rec_slot),   2);
      rec_ready = 1'b1;
      cyc(6);
      chk("drained_1", 64'(fifo_count), 0);

      // overflow: five sessions, ready low, fifth record dropped
      rec_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) expect_rec(4'(k + 8), 1, 33'(300 * k), 2'd1, 8'd0);
         sess(1, 16'(100 * k), 16'd3, 4'(k + 8), 4'b0100, 0, 8'd0);
      end
      cyc(2);
      chk("ovf_count",    64'(fifo_count), 4);
      chk("ovf_overflow", 64'(overflow),   1);
      chk("ovf_drop",     64'(drop_cnt),   1);
      chk("ovf_head",     64'(rec_slot),   9);
      rec_ready = 1'b1;
      cyc(6);
      chk("drained_2",    64'(fifo_count), 0);
      chk("ovf_sticky",   64'(overflow),   1);

      // reset mid-session with a record still queued
      rec_ready = 1'b0;
      expect_rec(4'd7, 2, 200, 2'd1, 8'd0);
      sess(2, 16'd10, 16'd10, 4'd7, 4'b0100, 0, 8'd0);
      cyc(2);
      chk("pre_rst_count", 64'(fifo_count), 1);
      charging = 1'b1; voltage = 16'd50; current = 16'd50; slot_id = 4'd4; state = 4'b0010;
      cyc(2);
      reset = 1'b1; charging = 1'b0; state = 4'b0001;
      #1;
      chk("mid_rst_active", 64'(active),      0);
      chk("mid_rst_live",   64'(live_energy), 0);
      chk("mid_rst_count",  64'(fifo_count),  0);
      exp_q.delete();
      cyc(1);
      reset = 1'b0; rec_ready = 1'b1;
      cyc(5);
      chk("post_rst_valid",    64'(rec_valid),  0);
      chk("post_rst_count",    64'(fifo_count), 0);
      chk("post_rst_overflow", 64'(overflow),   0);
      chk("post_rst_drop",     64'(drop_cnt),   0);

      chk("exp_q_empty", 64'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
